// File: rtl/l1_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : l1_cache_pkg
// Description : Shared types and helpers for the l1_cache block: controller
//               state encoding, default geometry and word-address split
//               functions (tag | index | offset, offset in the LSBs).
// Revision    : 1.0 - initial release
// ============================================================================
package l1_cache_pkg;

    localparam int c_ADDR_W          = 15;
    localparam int c_DEF_N           = 32;
    localparam int c_DEF_BLOCK_SIZE  = 16;
    localparam int c_DEF_NUM_LINES   = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITEBACK = 3'd1,
        S_FLUSH     = 3'd2,
        S_ALLOCATE  = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    // Word offset within the line, zero-extended to the address width.
    function automatic logic [c_ADDR_W-1:0] addr_offset(input logic [c_ADDR_W-1:0] addr,
                                                        input int ow);
        return addr & ((c_ADDR_W'(1) << ow) - c_ADDR_W'(1));
    endfunction

    // Line index, zero-extended to the address width.
    function automatic logic [c_ADDR_W-1:0] addr_index(input logic [c_ADDR_W-1:0] addr,
                                                       input int ow, input int iw);
        return (addr >> ow) & ((c_ADDR_W'(1) << iw) - c_ADDR_W'(1));
    endfunction

    // Tag bits, zero-extended to the address width.
    function automatic logic [c_ADDR_W-1:0] addr_tag(input logic [c_ADDR_W-1:0] addr,
                                                     input int ow, input int iw);
        return addr >> (ow + iw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_addr_split.sv
`default_nettype none
// ============================================================================
// Module      : l1_addr_split
// Description : Combinational decode of a 15-bit core word address into
//               tag, line index and word offset.
// Ports       : i_addr   - word address
//               o_tag    - upper 15-IW-OW bits
//               o_index  - line index (IW bits)
//               o_offset - word offset in line (OW bits)
// Revision    : 1.0 - initial release
// ============================================================================
module l1_addr_split
    import l1_cache_pkg::*;
#(
    parameter int OW = 4,
    parameter int IW = 6
) (
    input  logic [c_ADDR_W-1:0]       i_addr,
    output logic [c_ADDR_W-OW-IW-1:0] o_tag,
    output logic [IW-1:0]             o_index,
    output logic [OW-1:0]             o_offset
);

    localparam int c_TW = c_ADDR_W - OW - IW;

    assign o_tag    = c_TW'(addr_tag(i_addr, OW, IW));
    assign o_index  = IW'(addr_index(i_addr, OW, IW));
    assign o_offset = OW'(addr_offset(i_addr, OW));

endmodule
`default_nettype wire

// File: rtl/l1_cache.sv
`default_nettype none
// ============================================================================
// Module      : l1_cache
// Description : Direct-mapped, write-back, write-allocate L1 data cache.
//               Hits finish in one cycle; misses stall the core (L1_busy)
//               while whole lines move word-serially to/from L2. L2 can
//               command a whole-cache flush.
// Options     : L1_PERF_COUNTERS_EN - adds 32-bit hit/miss counters.
// Ports       : clk, reset (async, active low)
//               core : dmem_word_address, dmem_wdata, load, store,
//                      dmem_rdata, L1_busy
//               L2   : L2_busy, L2_read_word, L2_write_word,
//                      L2_word_address, L2_read_request,
//                      L2_write_request, flush
// Revision    : 1.0 - initial release
// ============================================================================
module l1_cache
    import l1_cache_pkg::*;
#(
    parameter int N          = c_DEF_N,
    parameter int BLOCK_SIZE = c_DEF_BLOCK_SIZE,
    parameter int NUM_LINES  = c_DEF_NUM_LINES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [c_ADDR_W-1:0] dmem_word_address,
    input  logic [N-1:0]        dmem_wdata,
    input  logic                load,
    input  logic                store,
    output logic [N-1:0]        dmem_rdata,
    output logic                L1_busy,
    input  logic                L2_busy,
    input  logic [N-1:0]        L2_read_word,
    output logic [N-1:0]        L2_write_word,
    output logic [c_ADDR_W-1:0] L2_word_address,
    output logic                L2_read_request,
    output logic                L2_write_request,
    input  logic                flush
);

    localparam int c_OW = $clog2(BLOCK_SIZE);
    localparam int c_IW = $clog2(NUM_LINES);
    localparam int c_TW = c_ADDR_W - c_IW - c_OW;
    localparam logic [c_OW-1:0] c_CNT_LAST  = c_OW'(BLOCK_SIZE - 1);
    localparam logic [c_IW-1:0] c_LINE_LAST = c_IW'(NUM_LINES - 1);

    state_t r_state, w_next_state;

    logic [N-1:0]    r_l1_cache_memory [NUM_LINES][BLOCK_SIZE];
    logic [c_TW-1:0] r_tag [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid, r_dirty;

    logic [c_OW-1:0] r_cnt;
    logic [c_IW-1:0] r_flush_idx;
    logic [c_IW-1:0] r_line_index;   // line currently being transferred
    logic            r_flushing;     // writeback returns to FLUSH, not ALLOCATE

    // Request captured at miss detection.
    logic [c_TW-1:0] r_req_tag;
    logic [c_OW-1:0] r_req_offset;
    logic [N-1:0]    r_req_wdata;
    logic            r_req_store;

`ifdef L1_PERF_COUNTERS_EN
    logic [31:0] r_hit_counter, r_miss_counter;
`endif

    logic [c_TW-1:0] w_input_tag;
    logic [c_IW-1:0] w_input_index;
    logic [c_OW-1:0] w_input_offset;
    logic            w_req, w_hit, w_last_word;

    logic            w_mem_we;
    logic [c_IW-1:0] w_mem_idx;
    logic [c_OW-1:0] w_mem_off;
    logic [N-1:0]    w_mem_wdata;
    logic            w_tag_we;

    l1_addr_split #(.OW(c_OW), .IW(c_IW)) u_addr_split (
        .i_addr   (dmem_word_address),
        .o_tag    (w_input_tag),
        .o_index  (w_input_index),
        .o_offset (w_input_offset)
    );

    assign w_req       = load | store;
    assign w_hit       = r_valid[w_input_index] && (r_tag[w_input_index] == w_input_tag);
    assign w_last_word = (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state     = r_state;
        L1_busy          = 1'b1;
        L2_read_request  = 1'b0;
        L2_write_request = 1'b0;
        L2_word_address  = '0;
        L2_write_word    = '0;
        w_mem_we         = 1'b0;
        w_mem_idx        = w_input_index;
        w_mem_off        = w_input_offset;
        w_mem_wdata      = dmem_wdata;
        w_tag_we         = 1'b0;
        case (r_state)
            S_IDLE: begin
                L1_busy = 1'b0;
                if (flush) begin
                    L1_busy      = 1'b1;
                    w_next_state = S_FLUSH;
                end else if (w_req && w_hit) begin
                    w_mem_we = store;
                end else if (w_req) begin
                    L1_busy      = 1'b1;
                    w_next_state = (r_valid[w_input_index] && r_dirty[w_input_index])
                                   ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                L2_write_request = 1'b1;
                L2_word_address  = {r_tag[r_line_index], r_line_index, r_cnt};
                L2_write_word    = r_l1_cache_memory[r_line_index][r_cnt];
                if (!L2_busy && w_last_word)
                    w_next_state = r_flushing ? S_FLUSH : S_ALLOCATE;
            end
            S_FLUSH: begin
                if (!L2_busy) begin
                    if (r_valid[r_flush_idx] && r_dirty[r_flush_idx])
                        w_next_state = S_WRITEBACK;
                    else if (r_flush_idx == c_LINE_LAST)
                        w_next_state = S_IDLE;
                end
            end
            S_ALLOCATE: begin
                L2_read_request = 1'b1;
                L2_word_address = {r_req_tag, r_line_index, r_cnt};
                if (!L2_busy) begin
                    w_mem_we    = 1'b1;
                    w_mem_idx   = r_line_index;
                    w_mem_off   = r_cnt;
                    w_mem_wdata = L2_read_word;
                    if (w_last_word) begin
                        w_tag_we     = 1'b1;
                        w_next_state = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                w_mem_we     = r_req_store;
                w_mem_idx    = r_line_index;
                w_mem_off    = r_req_offset;
                w_mem_wdata  = r_req_wdata;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Data and tag arrays carry no reset; validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_l1_cache_memory[w_mem_idx][w_mem_off] <= w_mem_wdata;
        if (w_tag_we) r_tag[r_line_index] <= r_req_tag;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid      <= '0;
            r_dirty      <= '0;
            r_cnt        <= '0;
            r_flush_idx  <= '0;
            r_line_index <= '0;
            r_flushing   <= 1'b0;
            r_req_tag    <= '0;
            r_req_offset <= '0;
            r_req_wdata  <= '0;
            r_req_store  <= 1'b0;
            dmem_rdata   <= '0;
`ifdef L1_PERF_COUNTERS_EN
            r_hit_counter  <= '0;
            r_miss_counter <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_flushing  <= 1'b1;
                        r_flush_idx <= '0;
                        r_cnt       <= '0;
                    end else if (w_req && w_hit) begin
                        if (store) r_dirty[w_input_index] <= 1'b1;
                        else       dmem_rdata <= r_l1_cache_memory[w_input_index][w_input_offset];
`ifdef L1_PERF_COUNTERS_EN
                        r_hit_counter <= r_hit_counter + 32'd1;
`endif
                    end else if (w_req) begin
                        r_req_tag    <= w_input_tag;
                        r_line_index <= w_input_index;
                        r_req_offset <= w_input_offset;
                        r_req_wdata  <= dmem_wdata;
                        r_req_store  <= store;
                        r_flushing   <= 1'b0;
                        r_cnt        <= '0;
`ifdef L1_PERF_COUNTERS_EN
                        r_miss_counter <= r_miss_counter + 32'd1;
`endif
                    end
                end
                S_WRITEBACK: begin
                    if (!L2_busy) begin
                        r_cnt <= r_cnt + 1'b1;  // wraps to 0 after the last word
                        // Clean after writeback so a flush walk does not revisit it.
                        if (w_last_word) r_dirty[r_line_index] <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (!L2_busy) begin
                        if (r_valid[r_flush_idx] && r_dirty[r_flush_idx]) begin
                            r_line_index <= r_flush_idx;
                            r_cnt        <= '0;
                        end else if (r_flush_idx == c_LINE_LAST) begin
                            r_valid     <= '0;
                            r_dirty     <= '0;
                            r_flush_idx <= '0;
                            r_flushing  <= 1'b0;
                        end else begin
                            r_flush_idx <= r_flush_idx + 1'b1;
                        end
                    end
                end
                S_ALLOCATE: begin
                    if (!L2_busy) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_word) begin
                            r_valid[r_line_index] <= 1'b1;
                            r_dirty[r_line_index] <= 1'b0;
                        end
                    end
                end
                S_RESPOND: begin
                    if (r_req_store) r_dirty[r_line_index] <= 1'b1;
                    else             dmem_rdata <= r_l1_cache_memory[r_line_index][r_req_offset];
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_cache
// Description : Directed self-checking bench for l1_cache: cold store miss
//               with an L2 stall, load hit, dirty-victim replacement,
//               simultaneous load/store, flush and mid-fill reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_cache;

    logic        clk;
    logic        reset;
    logic [14:0] dmem_word_address;
    logic [31:0] dmem_wdata;
    logic        load, store;
    logic [31:0] dmem_rdata;
    logic        L1_busy;
    logic        L2_busy;
    logic [31:0] L2_read_word;
    logic [31:0] L2_write_word;
    logic [14:0] L2_word_address;
    logic        L2_read_request, L2_write_request;
    logic        flush;

    int n_checks = 0;
    int n_pass   = 0;

    l1_cache dut (
        .clk               (clk),
        .reset             (reset),
        .dmem_word_address (dmem_word_address),
        .dmem_wdata        (dmem_wdata),
        .load              (load),
        .store             (store),
        .dmem_rdata        (dmem_rdata),
        .L1_busy           (L1_busy),
        .L2_busy           (L2_busy),
        .L2_read_word      (L2_read_word),
        .L2_write_word     (L2_write_word),
        .L2_word_address   (L2_word_address),
        .L2_read_request   (L2_read_request),
        .L2_write_request  (L2_write_request),
        .flush             (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  i;
        int  nw;
        bit  stalled;
        bit  done;

        reset = 1'b0; dmem_word_address = '0; dmem_wdata = '0;
        load = 1'b0; store = 1'b0; L2_busy = 1'b0; L2_read_word = '0; flush = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", dut.r_state, 0);
        chk("rst_busy", L1_busy, 0);
        chk("rst_rreq", L2_read_request, 0);
        chk("rst_wreq", L2_write_request, 0);
        chk("rst_rdata", dmem_rdata, 0);
        chk("rst_addr", L2_word_address, 0);
        chk("rst_valid", dut.r_valid == 64'd0, 1);
        reset = 1'b1;
        tick();

        // Cold store miss: addr 1000 = tag 0, index 62, offset 8
        dmem_word_address = 15'd1000; dmem_wdata = 32'd8; store = 1'b1;
        #1;
        chk("miss_busy_comb", L1_busy, 1);
        tick();
        store = 1'b0;
        chk("miss_state_alloc", dut.r_state, 3);
`ifdef L1_PERF_COUNTERS_EN
        chk("miss_counter_1", dut.r_miss_counter, 1);
`endif
        i = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && i < 16; cyc++) begin
            chk("fill1_rreq", L2_read_request, 1);
            chk("fill1_addr", L2_word_address, 992 + i);
            L2_read_word = 32'(5 * i);
            if (i == 4 && !stalled) begin
                L2_busy = 1'b1;
                stalled = 1'b1;
            end else begin
                L2_busy = 1'b0;
                i++;
            end
            tick();
        end
        L2_busy = 1'b0;
        chk("fill1_words", i, 16);
        chk("respond_state", dut.r_state, 4);
        chk("respond_busy", L1_busy, 1);
        tick();
        chk("store_idle", dut.r_state, 0);
        chk("store_busy", L1_busy, 0);
        chk("line_w8", dut.r_l1_cache_memory[62][8], 8);
        chk("line_w3", dut.r_l1_cache_memory[62][3], 15);
        chk("line_w4", dut.r_l1_cache_memory[62][4], 20);
        chk("line_w15", dut.r_l1_cache_memory[62][15], 75);
        chk("line_dirty", dut.r_dirty[62], 1);
        chk("line_valid", dut.r_valid[62], 1);

        // Load hit on 1000
        load = 1'b1;
        #1;
        chk("hit_busy", L1_busy, 0);
        tick();
        load = 1'b0;
        chk("hit_rdata", dmem_rdata, 8);
        chk("hit_state", dut.r_state, 0);
`ifdef L1_PERF_COUNTERS_EN
        chk("hit_counter_1", dut.r_hit_counter, 1);
`endif

        // Conflict miss 2024 = tag 1, index 62, offset 8; victim dirty
        dmem_word_address = 15'd2024; load = 1'b1;
        #1;
        chk("conf_busy_comb", L1_busy, 1);
        tick();
        load = 1'b0;
        chk("conf_state_wb", dut.r_state, 1);
        for (int k = 0; k < 16; k++) begin
            chk("wb_wreq", L2_write_request, 1);
            chk("wb_addr", L2_word_address, 992 + k);
            chk("wb_word", L2_write_word, (k == 8) ? 8 : 5 * k);
            tick();
        end
        chk("conf_state_alloc", dut.r_state, 3);
        for (int k = 0; k < 16; k++) begin
            chk("fill2_addr", L2_word_address, 2016 + k);
            L2_read_word = 32'(100 + k);
            tick();
        end
        tick();
        chk("conf_idle", dut.r_state, 0);
        chk("conf_rdata", dmem_rdata, 108);
        chk("conf_busy", L1_busy, 0);
        chk("conf_dirty", dut.r_dirty[62], 0);

        // Load and store together on a hit: store wins
        load = 1'b1; store = 1'b1; dmem_wdata = 32'd77;
        #1;
        chk("ls_busy", L1_busy, 0);
        tick();
        load = 1'b0; store = 1'b0;
        chk("ls_rdata_kept", dmem_rdata, 108);
        chk("ls_word", dut.r_l1_cache_memory[62][8], 77);
        chk("ls_dirty", dut.r_dirty[62], 1);

        // Flush with one dirty line (index 62, tag 1)
        flush = 1'b1;
        #1;
        chk("flush_busy_comb", L1_busy, 1);
        tick();
        flush = 1'b0;
        nw = 0; done = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!L1_busy) begin
                done = 1'b1;
                break;
            end
            if (L2_write_request) begin
                chk("flush_addr", L2_word_address, 2016 + nw);
                if (nw == 8) chk("flush_w8", L2_write_word, 77);
                nw++;
            end
            tick();
        end
        chk("flush_done", done, 1);
        chk("flush_words", nw, 16);
        chk("flush_valid", dut.r_valid == 64'd0, 1);
        chk("flush_dirty", dut.r_dirty == 64'd0, 1);

        // Reload after flush misses; then reset in the middle of the fill
        load = 1'b1;
        #1;
        chk("post_flush_miss", L1_busy, 1);
        tick();
        load = 1'b0;
        chk("post_flush_alloc", dut.r_state, 3);
`ifdef L1_PERF_COUNTERS_EN
        chk("miss_counter_3", dut.r_miss_counter, 3);
        chk("hit_counter_2", dut.r_hit_counter, 2);
`endif
        for (int k = 0; k < 5; k++) begin
            L2_read_word = 32'(k);
            tick();
        end
        chk("pre_rst_rreq", L2_read_request, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_state", dut.r_state, 0);
        chk("arst_busy", L1_busy, 0);
        chk("arst_rreq", L2_read_request, 0);
        chk("arst_wreq", L2_write_request, 0);
        chk("arst_valid", dut.r_valid[62], 0);
        tick();
        reset = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
